// File: rtl/dsc_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler and its arbiter.
package dsc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH = 5;
  localparam int DEF_NUM_INPUTS = 2;

  typedef logic [DEF_NUM_INPUTS-1:0][DEF_DATA_WIDTH-1:0] operand_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsc_rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_ptr, wrapping.
module dsc_rr_arbiter
  import dsc_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx
);

  int   w_k;
  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % NUM_REQ;
      if (i_en && !w_found && i_req[w_k]) begin
        w_found        = 1'b1;
        o_gnt[w_k]     = 1'b1;
        o_gnt_idx      = ID_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/dsc_mul_scheduler.sv
// Shares one stochastic multiplier among NUM_REQ requesters: round-robin grant,
// clear/run/monitor with timeout, then a tagged response over valid/ready.
module dsc_mul_scheduler
  import dsc_sched_pkg::*;
#(
  parameter  int DATA_WIDTH     = 5,
  parameter  int NUM_INPUTS     = 2,
  parameter  int WXIP1          = 1,
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = clog2_w(NUM_REQ)
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic [NUM_REQ-1:0]                             i_req_valid,
  output logic [NUM_REQ-1:0]                             o_req_ready,
  input  logic [NUM_REQ-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] i_req_data,
  output logic                                           o_rsp_valid,
  input  logic                                           i_rsp_ready,
  output logic [ID_W-1:0]                                o_rsp_id,
  output logic [WXIP1-1:0]                               o_rsp_data,
  output logic                                           o_rsp_err,
  output logic                                           o_mul_rst,
  output logic                                           o_mul_en,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]          o_mul_data,
  input  logic [WXIP1-1:0]                               i_mul_result,
  input  logic                                           i_mul_done
);

  localparam int              CNT_W    = clog2_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                                r_state, w_state_nxt;
  logic [ID_W-1:0]                       r_rr_ptr, w_gnt_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]                    w_gnt;
  logic [CNT_W-1:0]                      r_cnt;
  logic                                  w_grant, w_done, w_timeout;
  logic                                  r_mul_rst, r_mul_en, r_rsp_valid, r_rsp_err;
  logic [ID_W-1:0]                       r_rsp_id;
  logic [WXIP1-1:0]                      r_rsp_data;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] r_mul_data;

  dsc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .i_en      (r_state == IDLE),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign o_req_ready = w_gnt;
  assign w_grant     = |w_gnt;
  assign w_ptr_nxt   = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
  // Done has priority over a timeout landing in the same cycle.
  assign w_done      = (r_state == RUN) && i_mul_done;
  assign w_timeout   = (r_state == RUN) && !i_mul_done && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = RUN;
      RUN:     if (w_done || w_timeout) w_state_nxt = RESP;
      RESP:    if (i_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_mul_rst   <= 1'b1;
      r_mul_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_mul_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // Strobes are decoded from the next state so they line up with it.
      r_mul_rst   <= (w_state_nxt == CLEAR);
      r_mul_en    <= (w_state_nxt == RUN);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (w_grant) begin
        r_mul_data <= i_req_data[w_gnt_idx];
        r_rsp_id   <= w_gnt_idx;
        r_rr_ptr   <= w_ptr_nxt;
      end
      if (r_state == CLEAR) r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= r_cnt + CNT_W'(1);
      if (w_done) begin
        r_rsp_data <= i_mul_result;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign o_mul_rst   = r_mul_rst;
  assign o_mul_en    = r_mul_en;
  assign o_mul_data  = r_mul_data;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dsc_mul_scheduler.sv
// Bench for dsc_mul_scheduler with a programmable-latency stub multiplier.
module tb_dsc_mul_scheduler;
  localparam int DW = 5, NI = 2, WX = 1, NR = 4, TO = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR-1:0][NI-1:0][DW-1:0] req_data;
  logic rsp_valid, rsp_ready, rsp_err, mul_rst, mul_en, mul_done;
  logic [1:0] rsp_id;
  logic [WX-1:0] rsp_data, mul_result;
  logic [NI-1:0][DW-1:0] mul_data;

  int n_cmp = 0, n_bad = 0, m_ptr = 0;
  int stub_lat = 5, scnt = 0;
  bit stub_never = 0, force_done = 0;

  int obs_gidx, obs_nlat;
  bit obs_ok;
  logic [NR-1:0] obs_ready, obs_rdy1;
  logic [NI-1:0][DW-1:0] obs_ops, obs_md1;
  logic obs_mrst1, obs_men1, obs_men2, obs_men_v, obs_vafter, obs_e;
  logic [1:0] obs_id;
  logic [WX-1:0] obs_d;

  dsc_mul_scheduler #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(WX), .NUM_REQ(NR),
                      .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_data(req_data), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_mul_rst(mul_rst), .o_mul_en(mul_en), .o_mul_data(mul_data),
    .i_mul_result(mul_result), .i_mul_done(mul_done));

  always #5 clk = ~clk;

  // Stub multiplier: done in the stub_lat-th enabled cycle, result = operand parity.
  always @(posedge clk) begin
    if (mul_rst) scnt <= 0;
    else if (mul_en) scnt <= scnt + 1;
  end
  assign mul_done   = force_done | (mul_en & ~stub_never & (scnt == stub_lat - 1));
  assign mul_result = ^mul_data;

  function automatic int model_pick(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++)
      if (v[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    return -1;
  endfunction

  task automatic rand_data();
    for (int r = 0; r < NR; r++) req_data[r] = (NI*DW)'($urandom);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_ptr = 0;
  endtask

  // Runs one job from the current negedge, recording observations; no checks here.
  task automatic run_job(input bit drop, input int stall, input bit hold);
    int n;
    obs_ok = 1'b1; obs_gidx = -1; n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
    if (req_ready == '0) begin obs_ok = 1'b0; return; end
    for (int r = 0; r < NR; r++) if (req_ready[r]) obs_gidx = r;
    obs_ready = req_ready;
    obs_ops   = req_data[obs_gidx];
    @(negedge clk);
    if (drop) req_valid[obs_gidx] = 1'b0;
    obs_mrst1 = mul_rst; obs_men1 = mul_en; obs_md1 = mul_data; obs_rdy1 = req_ready;
    @(negedge clk);
    obs_men2 = mul_en;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    if (!rsp_valid) begin obs_ok = 1'b0; return; end
    obs_nlat = n; obs_id = rsp_id; obs_d = rsp_data; obs_e = rsp_err; obs_men_v = mul_en;
    if (hold) return;
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_vafter = rsp_valid;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mul_rst !== 1'b1) begin n_bad++; $display("FAIL reset_mul_rst got %b want 1", mul_rst); end
    n_cmp++; if ({mul_en, rsp_valid, rsp_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {mul_en, rsp_valid, rsp_err}); end
    n_cmp++; if ({mul_data, rsp_id, rsp_data} !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", {mul_data, rsp_id, rsp_data}); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0; m_ptr = 0;
    @(negedge clk);
    n_cmp++; if (mul_rst !== 1'b0) begin n_bad++; $display("FAIL reset_release_mul_rst got %b want 0", mul_rst); end
  endtask

  task automatic test_single();
    rand_data();
    req_data[2][1] = 5'd16; req_data[2][0] = 5'd8;
    req_valid = 4'b0100; stub_lat = 10; stub_never = 0;
    run_job(1'b1, 0, 1'b0);
    n_cmp++; if (obs_ok !== 1'b1) begin n_bad++; $display("FAIL single_timeout got %b want 1", obs_ok); end
    n_cmp++; if (obs_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", obs_ready); end
    n_cmp++; if ({obs_mrst1, obs_men1} !== 2'b10) begin n_bad++; $display("FAIL single_t1 rst/en got %b want 10", {obs_mrst1, obs_men1}); end
    n_cmp++; if (obs_md1 !== {5'd16, 5'd8}) begin n_bad++; $display("FAIL single_mul_data got %h want %h", obs_md1, {5'd16, 5'd8}); end
    n_cmp++; if (obs_rdy1 !== 4'b0000) begin n_bad++; $display("FAIL single_ready_busy got %b want 0000", obs_rdy1); end
    n_cmp++; if (obs_men2 !== 1'b1) begin n_bad++; $display("FAIL single_t2_en got %b want 1", obs_men2); end
    n_cmp++; if (obs_nlat !== 10) begin n_bad++; $display("FAIL single_latency got %0d want 10", obs_nlat); end
    n_cmp++; if ({obs_id, obs_e, obs_d} !== {2'd2, 1'b0, 1'b0}) begin n_bad++; $display("FAIL single_rsp id/err/data got %b want 1000", {obs_id, obs_e, obs_d}); end
    n_cmp++; if (obs_men_v !== 1'b0) begin n_bad++; $display("FAIL single_en_at_rsp got %b want 0", obs_men_v); end
    n_cmp++; if (obs_vafter !== 1'b0) begin n_bad++; $display("FAIL single_rsp_drop got %b want 0", obs_vafter); end
    m_ptr = 3;
  endtask

  task automatic test_pair();
    int exp_g [3] = '{0, 3, 0};
    pulse_reset();
    req_valid = 4'b1001;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) req_valid = 4'b1001;
      rand_data(); stub_lat = $urandom_range(1, 8);
      run_job(1'b1, 0, 1'b0);
      n_cmp++; if (obs_gidx !== exp_g[j] || obs_ok !== 1'b1) begin n_bad++; $display("FAIL pair_gnt job%0d got %0d want %0d", j, obs_gidx, exp_g[j]); end
      n_cmp++; if (obs_id !== 2'(exp_g[j])) begin n_bad++; $display("FAIL pair_id job%0d got %0d want %0d", j, obs_id, exp_g[j]); end
      m_ptr = (exp_g[j] + 1) % NR;
    end
    req_valid = '0;
  endtask

  task automatic test_jobs(input string nm, input int njobs, input bit all_valid);
    int exp_g, lat, exp_n;
    logic exp_e;
    logic [WX-1:0] exp_d;
    if (all_valid) req_valid = 4'hF;
    for (int j = 0; j < njobs; j++) begin
      if (!all_valid) req_valid = 4'($urandom_range(1, 15));
      rand_data();
      lat = all_valid ? $urandom_range(1, 12) : $urandom_range(1, 20);
      stub_lat = lat;
      exp_g = model_pick(req_valid);
      run_job(!all_valid, $urandom_range(0, 3), 1'b0);
      exp_n = (lat < TO) ? lat : TO;
      exp_e = (lat > TO);
      exp_d = exp_e ? '0 : ^obs_ops;
      n_cmp++; if (obs_ok !== 1'b1 || obs_gidx !== exp_g) begin n_bad++; $display("FAIL %s_gnt job%0d got %0d want %0d", nm, j, obs_gidx, exp_g); end
      n_cmp++; if (obs_id !== 2'(exp_g) || obs_e !== exp_e || obs_d !== exp_d) begin n_bad++; $display("FAIL %s_rsp job%0d got id%0d e%b d%b want id%0d e%b d%b", nm, j, obs_id, obs_e, obs_d, exp_g, exp_e, exp_d); end
      n_cmp++; if (obs_nlat !== exp_n) begin n_bad++; $display("FAIL %s_latency job%0d got %0d want %0d", nm, j, obs_nlat, exp_n); end
      m_ptr = (exp_g + 1) % NR;
    end
    req_valid = '0;
  endtask

  task automatic test_rsp_stall();
    logic [1:0] id0; logic e0; logic [WX-1:0] d0;
    int exp_g;
    req_valid = 4'hF; rand_data(); stub_lat = 3;
    exp_g = model_pick(req_valid);
    run_job(1'b0, 0, 1'b1);
    m_ptr = (exp_g + 1) % NR;
    id0 = rsp_id; e0 = rsp_err; d0 = rsp_data;
    n_cmp++; if (id0 !== 2'(exp_g) || obs_ok !== 1'b1) begin n_bad++; $display("FAIL stall_id got %0d want %0d", id0, exp_g); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, id0, e0, d0}) begin n_bad++; $display("FAIL stall_hold cyc%0d got %b want %b", i, {rsp_valid, rsp_id, rsp_err, rsp_data}, {1'b1, id0, e0, d0}); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready cyc%0d got %b want 0000", i, req_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    exp_g = model_pick(req_valid);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_accept got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 4'(1 << exp_g)) begin n_bad++; $display("FAIL stall_idle_ready got %b want %b", req_ready, 4'(1 << exp_g)); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lats [3] = '{0, 16, 17};
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b0010; rand_data();
      stub_never = (lats[j] == 0); stub_lat = (lats[j] == 0) ? 1 : lats[j];
      run_job(1'b1, 1, 1'b0);
      n_cmp++; if (obs_ok !== 1'b1 || obs_nlat !== TO) begin n_bad++; $display("FAIL timeout_latency case%0d got %0d want %0d", j, obs_nlat, TO); end
      n_cmp++; if (obs_e !== (j != 1) || obs_d !== ((j == 1) ? ^obs_ops : 1'b0)) begin n_bad++; $display("FAIL timeout_rsp case%0d got e%b d%b", j, obs_e, obs_d); end
      m_ptr = 2;
    end
    stub_never = 0;
  endtask

  task automatic test_done_outside_run();
    int seen = 0;
    req_valid = '0; force_done = 1'b1;
    repeat (6) begin @(negedge clk); if (rsp_valid || mul_en) seen++; end
    force_done = 1'b0;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL idle_done_ignored got %0d active cycles want 0", seen); end
  endtask

  task automatic test_reset_mid_run();
    int n = 0, seen = 0;
    req_valid = 4'b0100; rand_data(); stub_never = 1'b1;
    #1;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);
    n_cmp++; if (mul_en !== 1'b1) begin n_bad++; $display("FAIL midrun_running got %b want 1", mul_en); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({mul_rst, mul_en, rsp_valid, rsp_err} !== 4'b1000) begin n_bad++; $display("FAIL midrun_async_flags got %b want 1000", {mul_rst, mul_en, rsp_valid, rsp_err}); end
    n_cmp++; if ({mul_data, rsp_id, rsp_data, req_ready} !== '0) begin n_bad++; $display("FAIL midrun_async_data got %h want 0", {mul_data, rsp_id, rsp_data, req_ready}); end
    @(negedge clk); rst = 1'b0; m_ptr = 0; stub_never = 1'b0;
    repeat (20) begin @(negedge clk); if (rsp_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrun_no_rsp got %0d want 0", seen); end
    req_valid = 4'b1001; rand_data(); stub_lat = 4;
    run_job(1'b1, 0, 1'b0);
    n_cmp++; if (obs_ok !== 1'b1 || obs_gidx !== 0 || obs_e !== 1'b0) begin n_bad++; $display("FAIL midrun_next_gnt got %0d e%b want 0 e0", obs_gidx, obs_e); end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_pair();
    test_jobs("b2b", 8, 1'b1);
    test_jobs("rand", 12, 1'b0);
    test_rsp_stall();
    test_timeout();
    test_done_outside_run();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
